// File: rtl/lsu_mem_stage.sv
// RV32I load/store unit: one req/ack data-memory transaction per issue, with store lane
// alignment, load extraction/extension and a bounded wait for the bus acknowledge.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [1:0]  err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e      state;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;

    logic        is_load, is_store, illegal, misaligned;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] shifted, load_fmt;

    assign is_load  = (opcode == 7'b0000011);
    assign is_store = (opcode == 7'b0100011);
    assign busy     = (state != StIdle);

    always_comb begin
        illegal = 1'b0;
        if (is_store) begin
            illegal = funct3[2] || (funct3 == 3'b011);
        end else if (is_load) begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Word lanes shifted down so the addressed byte/half sits at bit 0.
    always_comb begin
        shifted = mem_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_fmt = {24'd0, shifted[7:0]};
            3'b101:  load_fmt = {16'd0, shifted[15:0]};
            default: load_fmt = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= 8'd0;
            f3_q      <= 3'd0;
            lane_q    <= 2'd0;
            done      <= 1'b0;
            rdata     <= 32'd0;
            err       <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start && (is_load || is_store)) begin
                        f3_q   <= funct3;
                        lane_q <= addr[1:0];
                        if (illegal || misaligned) begin
                            state <= StDone;
                            done  <= 1'b1;
                            err   <= illegal ? 2'b11 : 2'b01;
                            rdata <= 32'd0;
                        end else begin
                            state     <= StReq;
                            cnt       <= 8'd0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= be_calc;
                            mem_wdata <= is_store ? wdata_calc : 32'd0;
                        end
                    end
                end
                StReq: begin
                    // Ack in the last allowed cycle takes priority over the timeout.
                    if (mem_ack) begin
                        state   <= StDone;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        err     <= 2'b00;
                        rdata   <= mem_we ? 32'd0 : load_fmt;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state   <= StDone;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        err     <= 2'b10;
                        rdata   <= 32'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: vector table driven through a task, completions checked by a
// scoreboard monitor, plus hand sequences for reset, ignored strobes and stray acks.
module tb_lsu_mem_stage;

    localparam int unsigned TO = 4;

    logic        clk, rst_n, start, busy, done, mem_req, mem_we, mem_ack;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  err;
    logic [3:0]  mem_be;

    int errors = 0;
    int checks = 0;

    lsu_mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          dly;   // req cycle carrying the ack (1 = first); 0 = never ack
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        we;
        logic [31:0] rd;
        logic [1:0]  err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic [1:0]  err;
    } exp_t;

    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;

    exp_t sb[$];
    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pops one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rdata", rdata, e.rd);
                check("err", {30'd0, err}, {30'd0, e.err});
            end
        end
    end

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        opcode = op;
        funct3 = f3;
        addr   = a;
        wdata  = wd;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        opcode = 7'd0;
        addr   = $urandom;
        wdata  = $urandom;
    endtask

    task automatic run_vec(input vec_t v, input bit start_in_done);
        exp_t e;
        int   reqs;
        e.rd  = v.rd;
        e.err = v.err;
        sb.push_back(e);
        issue(v.op, v.f3, v.addr, v.wd);
        if (v.err == 2'b01 || v.err == 2'b11) begin
            check("err_no_req", {31'd0, mem_req}, 32'd0);
            check("err_done_lat", {31'd0, done}, 32'd1);
        end else begin
            check("req_rise", {31'd0, mem_req}, 32'd1);
            check("mem_we", {31'd0, mem_we}, {31'd0, v.we});
            check("mem_addr", mem_addr, v.maddr);
            check("mem_be", {28'd0, mem_be}, {28'd0, v.be});
            check("mem_wdata", mem_wdata, v.mwd);
            if (v.dly == 0) begin
                reqs = 0;
                for (int j = 0; j < 12 && !done; j++) begin
                    if (mem_req) reqs++;
                    mem_rdata = $urandom;
                    @(negedge clk);
                end
                check("timeout_req_cycles", reqs, TO);
                check("timeout_done", {31'd0, done}, 32'd1);
            end else begin
                for (int j = 1; j < v.dly; j++) begin
                    mem_rdata = $urandom;
                    @(negedge clk);
                    check("req_hold", {31'd0, mem_req}, 32'd1);
                end
                check("be_stable", {28'd0, mem_be}, {28'd0, v.be});
                mem_ack   = 1'b1;
                mem_rdata = v.mrd;
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
                check("done_lat", {31'd0, done}, 32'd1);
            end
            check("req_drop", {31'd0, mem_req}, 32'd0);
        end
        if (start_in_done) begin
            opcode = ST;
            funct3 = 3'b010;
            addr   = 32'h200;
            start  = 1'b1;
        end
        @(negedge clk);
        start  = 1'b0;
        opcode = 7'd0;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; opcode = 7'd0; funct3 = 3'd0; addr = 32'd0;
        wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

        //        op  f3      addr          wdata         mem_rdata     dly be  maddr
        //        mwd           we rdata          err
        vecs[0]  = '{ST, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3, 4'b1111, 32'h100,
                     32'hDEADBEEF, 1'b1, 32'h0, 2'b00};
        vecs[1]  = '{LD, 3'b000, 32'h103, 32'h0, 32'h80AA5511, 1, 4'b1000, 32'h100,
                     32'h0, 1'b0, 32'hFFFFFF80, 2'b00};
        vecs[2]  = '{LD, 3'b100, 32'h103, 32'h0, 32'h80AA5511, 2, 4'b1000, 32'h100,
                     32'h0, 1'b0, 32'h00000080, 2'b00};
        vecs[3]  = '{ST, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1, 4'b1100, 32'h100,
                     32'hABCDABCD, 1'b1, 32'h0, 2'b00};
        vecs[4]  = '{LD, 3'b101, 32'h102, 32'h0, 32'hABCD0000, 1, 4'b1100, 32'h100,
                     32'h0, 1'b0, 32'h0000ABCD, 2'b00};
        vecs[5]  = '{LD, 3'b001, 32'h100, 32'h0, 32'h12348001, 2, 4'b0011, 32'h100,
                     32'h0, 1'b0, 32'hFFFF8001, 2'b00};
        vecs[6]  = '{ST, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1, 4'b0010, 32'h100,
                     32'hA5A5A5A5, 1'b1, 32'h0, 2'b00};
        vecs[7]  = '{LD, 3'b010, 32'h104, 32'h0, 32'h12345678, 1, 4'b1111, 32'h104,
                     32'h0, 1'b0, 32'h12345678, 2'b00};
        vecs[8]  = '{LD, 3'b010, 32'h101, 32'h0, 32'h0, 1, 4'b0, 32'h0,
                     32'h0, 1'b0, 32'h0, 2'b01};
        vecs[9]  = '{ST, 3'b100, 32'h100, 32'h0, 32'h0, 1, 4'b0, 32'h0,
                     32'h0, 1'b0, 32'h0, 2'b11};
        vecs[10] = '{ST, 3'b001, 32'h103, 32'h0, 32'h0, 1, 4'b0, 32'h0,
                     32'h0, 1'b0, 32'h0, 2'b01};
        vecs[11] = '{LD, 3'b110, 32'h100, 32'h0, 32'h0, 1, 4'b0, 32'h0,
                     32'h0, 1'b0, 32'h0, 2'b11};
        vecs[12] = '{ST, 3'b011, 32'h100, 32'h0, 32'h0, 1, 4'b0, 32'h0,
                     32'h0, 1'b0, 32'h0, 2'b11};
        vecs[13] = '{ST, 3'b010, 32'h108, 32'h55AA55AA, 32'h0, 0, 4'b1111, 32'h108,
                     32'h55AA55AA, 1'b1, 32'h0, 2'b10};
        vecs[14] = '{LD, 3'b010, 32'h10C, 32'h0, 32'hCAFEF00D, 4, 4'b1111, 32'h10C,
                     32'h0, 1'b0, 32'hCAFEF00D, 2'b00};

        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_be", {28'd0, mem_be}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], 1'b0);

        // Non-memory opcode and a stray ack while idle must both be ignored.
        issue(7'b0110011, 3'b000, 32'h100, 32'h0);
        check("bad_op_busy", {31'd0, busy}, 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("stray_ack_done", {31'd0, done}, 32'd0);
        check("stray_ack_busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a request drops mem_req and busy at once.
        issue(ST, 3'b010, 32'h100, 32'h11111111);
        check("pre_rst_req", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, mem_req}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh store after reset, with a start pulse during DONE that must be ignored.
        run_vec(vecs[0], 1'b1);
        @(negedge clk);
        check("done_start_ignored", {31'd0, busy}, 32'd0);

        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
